// File: rtl/rs232_module.sv
// rtl/rs232_module.sv - 8N1 UART with 8-deep TX FIFO and 8-entry circular RX register file.
module rs232_module #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRX,
  output logic       oTX,
  input  logic [7:0] iData,
  input  logic       WriteEnable,
  output logic       oWrBuffer_full,
  output logic [7:0] oData,
  input  logic [2:0] read_addr,
  output logic [2:0] oRx_addr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic [7:0]    fifo_q [8];
  logic [2:0]    wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic          full_q;
  logic          push, pop;

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;

  logic          rx_s1_q, rx_s2_q;
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_mem_q [8];
  logic [2:0]    rx_addr_q;

  // Pops happen from IDLE or on the last STOP cycle, so frames run back-to-back.
  always_comb begin
    push = WriteEnable && !full_q;
    pop  = (count_q != 4'd0) &&
           ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_cnt_q == BIT_LAST));
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 4'd1;
    else if (pop && !push) count_d = count_q - 4'd1;
  end

  always_ff @(posedge iClk) begin
    if (push) fifo_q[wr_ptr_q] <= iData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 3'd1;
      count_q <= count_d;
      full_q  <= (count_d == 4'd8);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (pop) begin
            tx_shift_q <= fifo_q[rd_ptr_q];
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (pop) begin
              tx_shift_q <= fifo_q[rd_ptr_q];
              tx_q       <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= iRX;
      rx_s2_q <= rx_s1_q;
    end
  end

  // START is entered on the edge where the synchronized line falls; samples land mid-bit.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_addr_q  <= 3'd0;
      for (int i = 0; i < 8; i++) rx_mem_q[i] <= 8'h00;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_s2_q && !rx_s1_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_s2_q) begin
              rx_mem_q[rx_addr_q] <= rx_shift_q;
              rx_addr_q           <= rx_addr_q + 3'd1;
              rx_state_q          <= RX_IDLE;
            end else begin
              rx_state_q <= RX_WAIT;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_s2_q) rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign oTX            = tx_q;
  assign oWrBuffer_full = full_q;
  assign oData          = rx_mem_q[read_addr];
  assign oRx_addr       = rx_addr_q;

endmodule

// File: tb/tb_rs232_module.sv
// tb/tb_rs232_module.sv - scoreboard bench for rs232_module: serial decode/encode against byte queues.
module tb_rs232_module;
  localparam int CPB = 8;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRX = 1'b1;
  logic       WriteEnable = 1'b0;
  logic [7:0] iData = 8'h00;
  logic [2:0] read_addr = 3'd0;
  logic       oTX, oWrBuffer_full;
  logic [7:0] oData;
  logic [2:0] oRx_addr;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] model_mem [8];
  int model_ptr = 0;
  bit mon_en = 0;

  rs232_module #(.CLKS_PER_BIT(CPB)) dut (
    .iClk(iClk), .iRst(iRst), .iRX(iRX), .oTX(oTX), .iData(iData),
    .WriteEnable(WriteEnable), .oWrBuffer_full(oWrBuffer_full),
    .oData(oData), .read_addr(read_addr), .oRx_addr(oRx_addr)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial line decoder: samples mid-bit and checks against the queue of accepted bytes.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    wait (mon_en);
    forever begin
      @(negedge oTX);
      repeat (CPB / 2) @(posedge iClk);
      #1 check("tx_start_bit", oTX, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge iClk);
        #1 b[i] = oTX;
      end
      repeat (CPB) @(posedge iClk);
      #1 check("tx_stop_bit", oTX, 1'b1);
      if (txq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", b);
      end else begin
        e = txq.pop_front();
        check("tx_byte", b, e);
      end
    end
  end

  // Receive pointer monitor: each advance retires one expected byte into the model memory.
  initial begin
    wait (mon_en);
    forever begin
      @(oRx_addr);
      if (!iRst) begin
        if (rxq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected_write: got addr %0d, expected no write", oRx_addr);
        end else begin
          model_mem[model_ptr] = rxq.pop_front();
          model_ptr = (model_ptr + 1) % 8;
          check("rx_addr_step", oRx_addr, model_ptr);
        end
      end
    end
  end

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    model_ptr = 0;
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge iClk) iRst = 1'b1;
    repeat (3) @(negedge iClk);
    model_clear();
    iRst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    if (stop_val) rxq.push_back(b);
    @(negedge iClk) iRX = 1'b0;
    repeat (CPB) @(negedge iClk);
    for (int i = 0; i < 8; i++) begin
      iRX = b[i];
      repeat (CPB) @(negedge iClk);
    end
    iRX = stop_val;
    repeat (CPB) @(negedge iClk);
    iRX = 1'b1;
    repeat (CPB) @(negedge iClk);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (txq.size() == 0 && rxq.size() == 0) break;
      @(posedge iClk);
    end
    check("drain_pending", txq.size() + rxq.size(), 0);
    repeat (20) @(negedge iClk);
    check("tx_idle_high", oTX, 1'b1);
  endtask

  task automatic scan_mem();
    for (int i = 0; i < 8; i++) begin
      @(negedge iClk) read_addr = 3'(i);
      #1 check($sformatf("rx_mem[%0d]", i), oData, model_mem[i]);
    end
  endtask

  task automatic tx_burst();
    int n;
    n = $urandom_range(1, 8);
    for (int k = 0; k < n; k++) begin
      @(negedge iClk);
      iData = 8'($urandom);
      WriteEnable = 1'b1;
      txq.push_back(iData);
      @(negedge iClk) WriteEnable = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge iClk);
    end
    check("burst_not_full", oWrBuffer_full, 1'b0);
  endtask

  task automatic rx_burst();
    for (int k = 0; k < 2; k++) send_frame(8'($urandom), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int model_cnt;
    model_clear();
    repeat (4) @(negedge iClk);
    iRst = 1'b0;
    mon_en = 1'b1;
    #1;
    check("reset_tx", oTX, 1'b1);
    check("reset_full", oWrBuffer_full, 1'b0);
    check("reset_rx_addr", oRx_addr, 3'd0);
    scan_mem();

    @(negedge iClk);
    iData = 8'hA5;
    WriteEnable = 1'b1;
    txq.push_back(8'hA5);
    @(posedge iClk) #1 check("tx_before_pop", oTX, 1'b1);
    @(negedge iClk) WriteEnable = 1'b0;
    @(posedge iClk) #1 check("tx_latency", oTX, 1'b0);
    drain();

    @(negedge iClk);
    iData = 8'($urandom);
    WriteEnable = 1'b1;
    txq.push_back(iData);
    @(negedge iClk) WriteEnable = 1'b0;
    repeat (3) @(negedge iClk);
    model_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge iClk);
      check($sformatf("full_before_push%0d", i), oWrBuffer_full, (model_cnt == 8));
      iData = 8'(i);
      WriteEnable = 1'b1;
      if (model_cnt < 8) begin
        txq.push_back(8'(i));
        model_cnt++;
      end
    end
    @(negedge iClk) WriteEnable = 1'b0;
    check("full_after_drop", oWrBuffer_full, 1'b1);
    drain();
    check("full_after_drain", oWrBuffer_full, 1'b0);

    send_frame(8'h3C, 1'b1);
    drain();
    check("rx_addr_after_3c", oRx_addr, 3'd1);
    @(negedge iClk) read_addr = 3'd0;
    #1 check("rx_data_3c", oData, 8'h3C);
    scan_mem();

    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1);
    drain();
    check("rx_addr_wrap", oRx_addr, 3'd1);
    @(negedge iClk) read_addr = 3'd0;
    #1 check("rx_mem0_wrap", oData, 8'h18);
    @(negedge iClk) read_addr = 3'd1;
    #1 check("rx_mem1_wrap", oData, 8'h11);
    scan_mem();

    @(negedge iClk) iRX = 1'b0;
    repeat (2) @(negedge iClk);
    iRX = 1'b1;
    repeat (40) @(negedge iClk);
    check("rx_addr_after_glitch", oRx_addr, 3'd1);
    send_frame(8'($urandom), 1'b0);
    repeat (20) @(negedge iClk);
    check("rx_addr_after_frame_err", oRx_addr, 3'd1);
    send_frame(8'h55, 1'b1);
    drain();
    check("rx_addr_after_55", oRx_addr, 3'd2);
    scan_mem();

    for (int r = 0; r < 3; r++) begin
      fork
        tx_burst();
        rx_burst();
      join
      drain();
      scan_mem();
    end

    repeat (10) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
